// File: rtl/rename_map_pkg.sv
// Shared sizing and register-index types for the dispatch-stage register alias table.
package rename_map_pkg;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int ARCH_REGS            = 32;
  localparam int PHYS_REGS            = 64;
  localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
  localparam int ARCH_REGS_ADDR_WIDTH = $clog2(ARCH_REGS);
  localparam int LANE_IDX_WIDTH       = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  typedef logic [ARCH_REGS_ADDR_WIDTH-1:0] arch_reg_t;
  typedef logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_reg_t;
  typedef logic [LANE_IDX_WIDTH-1:0]       lane_idx_t;
endpackage

// File: rtl/rename_map_bypass.sv
// Combinational per-lane allocation compaction and intra-group source/old-rd bypass.
module rename_bypass
  import rename_map_pkg::*;
(
  input  logic [DISPATCH_WIDTH-1:0]                           wen,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] rs1,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] rs2,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] map_rs1,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] map_rs2,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] map_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] pop_reg,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rs1,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rs2,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rd,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] old_phys_rd,
  output logic [DISPATCH_WIDTH-1:0]                           pop_req
);
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] alloc;
  lane_idx_t cnt;

  // Free-list head entries are consumed in order, so the pop request is a
  // thermometer of the allocation count rather than the lane write mask.
  always_comb begin
    alloc   = '0;
    pop_req = '0;
    cnt     = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      alloc[i] = pop_reg[cnt];
      if (wen[i]) begin
        pop_req[cnt] = 1'b1;
        cnt          = cnt + lane_idx_t'(1);
      end
    end
  end

  // Ascending scan over lower lanes leaves the newest producer in place.
  always_comb begin
    phys_rs1    = '0;
    phys_rs2    = '0;
    phys_rd     = '0;
    old_phys_rd = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      phys_rs1[i]    = (rs1[i] == '0) ? '0 : map_rs1[i];
      phys_rs2[i]    = (rs2[i] == '0) ? '0 : map_rs2[i];
      old_phys_rd[i] = map_rd[i];
      for (int j = 0; j < i; j++) begin
        if (wen[j] && rd[j] == rs1[i]) phys_rs1[i] = alloc[j];
        if (wen[j] && rd[j] == rs2[i]) phys_rs2[i] = alloc[j];
        if (wen[j] && rd[j] == rd[i])  old_phys_rd[i] = alloc[j];
      end
      if (wen[i]) phys_rd[i] = alloc[i];
      else        old_phys_rd[i] = '0;
    end
  end
endmodule

// File: rtl/rename_map.sv
// Register alias table: speculative and committed maps, free-list pops and a one-deep output register.
module rename_map
  import rename_map_pkg::*;
(
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                flush,
  input  logic [DISPATCH_WIDTH-1:0]                           in_valid,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] in_rs1,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] in_rs2,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] in_rd,
  input  logic [DISPATCH_WIDTH-1:0]                           in_rd_wen,
  output logic                                                in_ready,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] fl_pop_reg,
  output logic [DISPATCH_WIDTH-1:0]                           fl_pop_en,
  input  logic                                                fl_empty,
  output logic [DISPATCH_WIDTH-1:0]                           out_valid,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rs1,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rs2,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_phys_rd,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] out_old_phys_rd,
  output logic [DISPATCH_WIDTH-1:0]                           out_rd_wen,
  input  logic                                                out_ready,
  input  logic [DISPATCH_WIDTH-1:0]                           commit_en,
  input  logic [DISPATCH_WIDTH-1:0][ARCH_REGS_ADDR_WIDTH-1:0] commit_rd,
  input  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd
);
  phys_reg_t spec_map    [ARCH_REGS];
  phys_reg_t commit_map  [ARCH_REGS];
  phys_reg_t commit_next [ARCH_REGS];
  phys_reg_t spec_wdata  [ARCH_REGS];
  logic [ARCH_REGS-1:0] spec_we;

  logic [DISPATCH_WIDTH-1:0] wen;
  logic [DISPATCH_WIDTH-1:0] pop_req;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] map_rs1, map_rs2, map_rd;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] b_rs1, b_rs2, b_rd, b_old;

  always_comb begin
    wen     = '0;
    map_rs1 = '0;
    map_rs2 = '0;
    map_rd  = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      wen[i]     = in_valid[i] & in_rd_wen[i] & (in_rd[i] != '0);
      map_rs1[i] = spec_map[in_rs1[i]];
      map_rs2[i] = spec_map[in_rs2[i]];
      map_rd[i]  = spec_map[in_rd[i]];
    end
  end

  rename_bypass u_bypass (
    .wen         (wen),
    .rs1         (in_rs1),
    .rs2         (in_rs2),
    .rd          (in_rd),
    .map_rs1     (map_rs1),
    .map_rs2     (map_rs2),
    .map_rd      (map_rd),
    .pop_reg     (fl_pop_reg),
    .phys_rs1    (b_rs1),
    .phys_rs2    (b_rs2),
    .phys_rd     (b_rd),
    .old_phys_rd (b_old),
    .pop_req     (pop_req)
  );

  assign in_ready  = rst & ~flush & ~fl_empty & (out_ready | ~|out_valid);
  assign fl_pop_en = in_ready ? pop_req : '0;

  // Same-cycle commits are folded in here so a flush restores them too.
  always_comb begin
    commit_next = commit_map;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (commit_en[i] && commit_rd[i] != '0) commit_next[commit_rd[i]] = commit_phys_rd[i];
  end

  always_comb begin
    spec_we = '0;
    for (int a = 0; a < ARCH_REGS; a++) spec_wdata[a] = '0;
    if (in_ready)
      for (int i = 0; i < DISPATCH_WIDTH; i++)
        if (wen[i]) begin
          spec_we[in_rd[i]]    = 1'b1;
          spec_wdata[in_rd[i]] = b_rd[i];
        end
  end

  for (genvar a = 0; a < ARCH_REGS; a++) begin : g_map
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        spec_map[a]   <= phys_reg_t'(a);
        commit_map[a] <= phys_reg_t'(a);
      end else begin
        commit_map[a] <= commit_next[a];
        if (flush)           spec_map[a] <= commit_next[a];
        else if (spec_we[a]) spec_map[a] <= spec_wdata[a];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid       <= '0;
      out_phys_rs1    <= '0;
      out_phys_rs2    <= '0;
      out_phys_rd     <= '0;
      out_old_phys_rd <= '0;
      out_rd_wen      <= '0;
    end else if (flush) begin
      out_valid <= '0;
    end else if (in_ready) begin
      out_valid       <= in_valid;
      out_phys_rs1    <= b_rs1;
      out_phys_rs2    <= b_rs2;
      out_phys_rd     <= b_rd;
      out_old_phys_rd <= b_old;
      out_rd_wen      <= wen;
    end else if (out_ready) begin
      out_valid <= '0;
    end
  end
endmodule

// File: tb/tb_rename_map.sv
// Randomized bench for rename_map against a sequential-rename reference model, with directed anchors.
module tb_rename_map;
  import rename_map_pkg::*;
  localparam int DW = DISPATCH_WIDTH;
  localparam int AW = ARCH_REGS_ADDR_WIDTH;
  localparam int PW = PHYS_REGS_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [DW-1:0] in_valid = '0, in_rd_wen = '0;
  logic [DW-1:0][AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic in_ready;
  logic [DW-1:0][PW-1:0] fl_pop_reg = '0;
  logic [DW-1:0] fl_pop_en;
  logic fl_empty = 1'b0;
  logic [DW-1:0] out_valid, out_rd_wen;
  logic [DW-1:0][PW-1:0] out_phys_rs1, out_phys_rs2, out_phys_rd, out_old_phys_rd;
  logic out_ready = 1'b1;
  logic [DW-1:0] commit_en = '0;
  logic [DW-1:0][AW-1:0] commit_rd = '0;
  logic [DW-1:0][PW-1:0] commit_phys_rd = '0;

  always #5 clk = ~clk;

  rename_map dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_ready(in_ready), .fl_pop_reg(fl_pop_reg), .fl_pop_en(fl_pop_en), .fl_empty(fl_empty),
    .out_valid(out_valid), .out_phys_rs1(out_phys_rs1), .out_phys_rs2(out_phys_rs2),
    .out_phys_rd(out_phys_rd), .out_old_phys_rd(out_old_phys_rd), .out_rd_wen(out_rd_wen),
    .out_ready(out_ready), .commit_en(commit_en), .commit_rd(commit_rd), .commit_phys_rd(commit_phys_rd)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: plain arrays holding arch -> phys, renamed one instruction at a time.
  int m_spec [ARCH_REGS];
  int m_comm [ARCH_REGS];
  logic [DW-1:0] m_ov;
  logic [DW-1:0] m_rdwen;
  int m_rs1 [DW];
  int m_rs2 [DW];
  int m_rd  [DW];
  int m_old [DW];
  typedef struct { int rd; int prd; } inflight_t;
  inflight_t infl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < ARCH_REGS; a++) begin
      m_spec[a] = a;
      m_comm[a] = a;
    end
    m_ov = '0;
    m_rdwen = '0;
    for (int i = 0; i < DW; i++) begin
      m_rs1[i] = 0; m_rs2[i] = 0; m_rd[i] = 0; m_old[i] = 0;
    end
    infl.delete();
  endtask

  function automatic int wen_count();
    int k = 0;
    for (int i = 0; i < DW; i++)
      if (in_valid[i] && in_rd_wen[i] && in_rd[i] != 0) k++;
    return k;
  endfunction

  task automatic model_update(input bit accept);
    int newcomm [ARCH_REGS];
    int tmp [ARCH_REGS];
    int k;
    newcomm = m_comm;
    for (int i = 0; i < DW; i++)
      if (commit_en[i] && commit_rd[i] != 0) newcomm[int'(commit_rd[i])] = int'(commit_phys_rd[i]);
    if (flush) begin
      m_spec = newcomm;
      m_ov = '0;
      infl.delete();
    end else if (accept) begin
      tmp = m_spec;
      k = 0;
      for (int i = 0; i < DW; i++) begin
        bit w;
        w = in_valid[i] && in_rd_wen[i] && in_rd[i] != 0;
        m_rs1[i] = (in_rs1[i] == 0) ? 0 : tmp[int'(in_rs1[i])];
        m_rs2[i] = (in_rs2[i] == 0) ? 0 : tmp[int'(in_rs2[i])];
        if (w) begin
          m_rd[i]  = int'(fl_pop_reg[k]);
          k++;
          m_old[i] = tmp[int'(in_rd[i])];
          tmp[int'(in_rd[i])] = m_rd[i];
          infl.push_back('{rd: int'(in_rd[i]), prd: m_rd[i]});
        end else begin
          m_rd[i]  = 0;
          m_old[i] = 0;
        end
        m_ov[i]    = in_valid[i];
        m_rdwen[i] = w;
      end
      m_spec = tmp;
    end else if (out_ready) begin
      m_ov = '0;
    end
    m_comm = newcomm;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < DW; i++) begin
      chk($sformatf("out_valid[%0d]", i), out_valid[i], m_ov[i]);
      if (m_ov[i]) begin
        chk($sformatf("out_phys_rs1[%0d]", i), out_phys_rs1[i], m_rs1[i]);
        chk($sformatf("out_phys_rs2[%0d]", i), out_phys_rs2[i], m_rs2[i]);
        chk($sformatf("out_phys_rd[%0d]", i), out_phys_rd[i], m_rd[i]);
        chk($sformatf("out_old_phys_rd[%0d]", i), out_old_phys_rd[i], m_old[i]);
        chk($sformatf("out_rd_wen[%0d]", i), out_rd_wen[i], m_rdwen[i]);
      end
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit exp_ready;
    logic [DW-1:0] exp_pop;
    #1;
    exp_ready = rst && !flush && !fl_empty && (out_ready || m_ov == '0);
    exp_pop = exp_ready ? DW'((1 << wen_count()) - 1) : '0;
    chk("in_ready", in_ready, exp_ready);
    chk("fl_pop_en", fl_pop_en, exp_pop);
    model_update(exp_ready);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_in();
    in_valid = '0; in_rd_wen = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    commit_en = '0; commit_rd = '0; commit_phys_rd = '0;
    flush = 1'b0;
  endtask

  task automatic set_lane(input int l, input int rs1, input int rs2, input int rd, input bit w);
    in_valid[l]  = 1'b1;
    in_rs1[l]    = AW'(rs1);
    in_rs2[l]    = AW'(rs2);
    in_rd[l]     = AW'(rd);
    in_rd_wen[l] = w;
  endtask

  task automatic set_pops(input int p0, input int p1);
    fl_pop_reg[0] = PW'(p0);
    fl_pop_reg[1] = PW'(p1);
  endtask

  // Asserts reset a little after a negedge, while the clock is low, then releases at the next negedge.
  task automatic mid_cycle_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fl_pop_en", fl_pop_en, 0);
    model_reset();
    @(negedge clk);
    chk("rst_out_phys_rd", out_phys_rd, 0);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_in();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_phys_rs1", out_phys_rs1, 0);
    chk("reset_out_phys_rd", out_phys_rd, 0);
    chk("reset_out_old_phys_rd", out_old_phys_rd, 0);
    chk("reset_fl_pop_en", fl_pop_en, 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b1;

    // add x5 <- x1, x2
    set_lane(0, 1, 2, 5, 1'b1);
    set_pops(32, 33);
    #1 chk("t1_pop_en", fl_pop_en, 2'b01);
    step();
    chk("t1_rs1", out_phys_rs1[0], 1);
    chk("t1_rs2", out_phys_rs2[0], 2);
    chk("t1_rd", out_phys_rd[0], 32);
    chk("t1_old", out_old_phys_rd[0], 5);

    // lane1 reads and rewrites x3 just produced by lane0
    clear_in();
    set_lane(0, 0, 0, 3, 1'b1);
    set_lane(1, 3, 0, 3, 1'b1);
    set_pops(32, 33);
    #1 chk("t2_pop_en", fl_pop_en, 2'b11);
    step();
    chk("t2_rd0", out_phys_rd[0], 32);
    chk("t2_old0", out_old_phys_rd[0], 3);
    chk("t2_rs1_1", out_phys_rs1[1], 32);
    chk("t2_rd1", out_phys_rd[1], 33);
    chk("t2_old1", out_old_phys_rd[1], 32);

    // lane0 targets x0, lane1 x7 takes the head entry
    clear_in();
    set_lane(0, 3, 5, 0, 1'b1);
    set_lane(1, 7, 0, 7, 1'b1);
    set_pops(34, 35);
    #1 chk("t3_pop_en", fl_pop_en, 2'b01);
    step();
    chk("t3_rs1_0_x3", out_phys_rs1[0], 33);
    chk("t3_rs2_0_x5", out_phys_rs2[0], 32);
    chk("t3_rd_wen", out_rd_wen, 2'b10);
    chk("t3_rd0", out_phys_rd[0], 0);
    chk("t3_rd1", out_phys_rd[1], 34);
    chk("t3_old1", out_old_phys_rd[1], 7);

    // downstream stall holds the group
    clear_in();
    set_lane(0, 1, 1, 9, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t4_stall_ready", in_ready, 0);
      step();
    end
    chk("t4_held_valid", out_valid, 2'b11);
    chk("t4_held_rd1", out_phys_rd[1], 34);
    out_ready = 1'b1;
    fl_empty = 1'b1;
    #1 chk("t4_empty_pop", fl_pop_en, 0);
    step();
    chk("t4_drained", out_valid, 0);
    fl_empty = 1'b0;

    // x4 -> 40 committed during flush survives, x6 -> 41 reverts
    clear_in();
    set_lane(0, 0, 0, 4, 1'b1);
    set_lane(1, 0, 0, 6, 1'b1);
    set_pops(40, 41);
    step();
    clear_in();
    set_lane(0, 4, 6, 8, 1'b1);
    flush = 1'b1;
    commit_en[0] = 1'b1;
    commit_rd[0] = AW'(4);
    commit_phys_rd[0] = PW'(40);
    #1 chk("t5_flush_pop", fl_pop_en, 0);
    step();
    chk("t5_flush_valid", out_valid, 0);
    clear_in();
    set_lane(0, 4, 6, 0, 1'b0);
    step();
    chk("t5_x4", out_phys_rs1[0], 40);
    chk("t5_x6", out_phys_rs2[0], 6);

    // reset while a group is stalled
    clear_in();
    set_lane(0, 4, 0, 10, 1'b1);
    set_pops(50, 51);
    out_ready = 1'b0;
    step();
    step();
    chk("t6_stalled", out_valid, 2'b01);
    mid_cycle_reset();
    out_ready = 1'b1;
    clear_in();
    set_lane(0, 4, 10, 0, 1'b0);
    step();
    chk("t6_x4_ident", out_phys_rs1[0], 4);
    chk("t6_x10_ident", out_phys_rs2[0], 10);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      clear_in();
      for (int l = 0; l < DW; l++) begin
        int r;
        in_valid[l]   = 1'($urandom_range(0, 1));
        in_rd_wen[l]  = 1'($urandom_range(0, 1));
        in_rs1[l]     = AW'($urandom_range(0, 7));
        in_rs2[l]     = AW'($urandom_range(0, 7));
        in_rd[l]      = AW'($urandom_range(0, 7));
        fl_pop_reg[l] = PW'($urandom_range(0, PHYS_REGS - 1));
        r = $urandom_range(0, 3);
        if (r == 0 && infl.size() > 0) begin
          inflight_t e;
          e = infl.pop_front();
          commit_en[l] = 1'b1;
          commit_rd[l] = AW'(e.rd);
          commit_phys_rd[l] = PW'(e.prd);
        end else if (r == 1) begin
          commit_en[l] = 1'b1;
          commit_rd[l] = AW'($urandom_range(0, 7));
          commit_phys_rd[l] = PW'($urandom_range(0, PHYS_REGS - 1));
        end
      end
      fl_empty  = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      if (cyc == 1500) mid_cycle_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
